// File: rtl/nxor_gate_if.sv
// Operand/result handshake bundle for nxor_gate.
// master drives operands and out_ready; slave is the XNOR unit.
interface nxor_gate_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             eq;
    logic [CntW-1:0]  match_cnt;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, eq, match_cnt
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, eq, match_cnt
    );
endinterface

// File: rtl/nxor_gate.sv
// Registered bitwise XNOR with equality flag and match popcount.
// Two-entry (OUT + SKID) buffer keeps full throughput with registered in_ready.
module nxor_gate #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    nxor_gate_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] res_c;
    logic             res_eq;
    logic [CntW-1:0]  res_cnt;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic             out_eq_q, out_eq_d;
    logic [CntW-1:0]  out_cnt_q, out_cnt_d;

    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_c_q, skid_c_d;
    logic             skid_eq_q, skid_eq_d;
    logic [CntW-1:0]  skid_cnt_q, skid_cnt_d;

    logic             in_ready_q, in_ready_d;
    logic             in_fire, out_fire;

    always_comb begin
        res_c   = ~(bus.a ^ bus.b);
        res_eq  = &res_c;
        res_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_cnt = res_cnt + CntW'(res_c[i]);
        end
    end

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_c_d      = out_c_q;
        out_eq_d     = out_eq_q;
        out_cnt_d    = out_cnt_q;
        skid_valid_d = skid_valid_q;
        skid_c_d     = skid_c_q;
        skid_eq_d    = skid_eq_q;
        skid_cnt_d   = skid_cnt_q;

        if (in_fire) begin
            if ((!out_valid_q || out_fire) && !skid_valid_q) begin
                out_valid_d = 1'b1;
                out_c_d     = res_c;
                out_eq_d    = res_eq;
                out_cnt_d   = res_cnt;
            end else begin
                skid_valid_d = 1'b1;
                skid_c_d     = res_c;
                skid_eq_d    = res_eq;
                skid_cnt_d   = res_cnt;
            end
        end else if (out_fire) begin
            if (skid_valid_q) begin
                out_c_d      = skid_c_q;
                out_eq_d     = skid_eq_q;
                out_cnt_d    = skid_cnt_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // in_ready is a flop tracking next-cycle SKID emptiness
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_c_q      <= '0;
            out_eq_q     <= 1'b0;
            out_cnt_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_c_q     <= '0;
            skid_eq_q    <= 1'b0;
            skid_cnt_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_c_q      <= out_c_d;
            out_eq_q     <= out_eq_d;
            out_cnt_q    <= out_cnt_d;
            skid_valid_q <= skid_valid_d;
            skid_c_q     <= skid_c_d;
            skid_eq_q    <= skid_eq_d;
            skid_cnt_q   <= skid_cnt_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = out_c_q;
    assign bus.eq        = out_eq_q;
    assign bus.match_cnt = out_cnt_q;
endmodule

// File: tb/tb_nxor_gate.sv
// Scoreboard bench for nxor_gate: WIDTH=32 random/directed traffic plus a WIDTH=1 instance.
module tb_nxor_gate;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nxor_gate_if #(.WIDTH(32)) bus ();
    nxor_gate_if #(.WIDTH(1))  bus1 ();

    nxor_gate #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    nxor_gate #(.WIDTH(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [31:0] c;
        logic        eq;
        int          cnt;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lat_chk  = 1'b0;

    logic [31:0] vec_a [5] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] vec_b [5] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h007FA509, 32'hFFFFFFFF};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: result defined directly from the operation rules
    function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb, input int c_at);
        exp_t e;
        e.c   = ~(aa ^ bb);
        e.eq  = (aa == bb);
        e.cnt = $countones(~(aa ^ bb));
        e.cyc = c_at;
        return e;
    endfunction

    // Monitor: pops on every output fire, also checks stability under backpressure
    logic        hold_pending = 1'b0;
    logic [31:0] held_c;
    logic        held_eq;
    logic [5:0]  held_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_c", 64'(bus.c), 64'(held_c));
                check("hold_eq", 64'(bus.eq), 64'(held_eq));
                check("hold_cnt", 64'(bus.match_cnt), 64'(held_cnt));
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            held_c   = bus.c;
            held_eq  = bus.eq;
            held_cnt = bus.match_cnt;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_output", 64'(bus.c), 64'hDEAD_0000_0000);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("c", 64'(bus.c), 64'(e.c));
                    check("eq", 64'(bus.eq), 64'(e.eq));
                    check("match_cnt", 64'(bus.match_cnt), 64'(e.cnt));
                    if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd1);
                end
            end
        end
    end

    // Present a pair until accepted; expected result is queued at the accept
    task automatic send(input logic [31:0] aa, input logic [31:0] bb);
        bus.in_valid = 1'b1;
        bus.a = aa;
        bus.b = bb;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(model(aa, bb, cyc));
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (q.size() != 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.out_ready = 1'b1;
        bus1.in_valid = 1'b1; bus1.a = 1'b0; bus1.b = 1'b0; bus1.out_ready = 1'b1;

        // Reset held two cycles with in_valid asserted
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_c", 64'(bus.c), 64'd0);
        check("rst_eq", 64'(bus.eq), 64'd0);
        check("rst_cnt", 64'(bus.match_cnt), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0; bus1.in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(bus.out_valid), 64'd0);

        // Directed sweep, one pair per cycle
        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++) send(vec_a[i], vec_b[i]);
        drain(10);

        // Backpressure: out_ready low, hold five pairs on the input
        lat_chk = 1'b0;
        bus.out_ready = 1'b0;
        acc = 0;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 8; t++) begin
            bus.a = vec_a[acc < 5 ? acc : 4];
            bus.b = vec_b[acc < 5 ? acc : 4];
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, cyc));
                acc++;
            end
            @(posedge clk); #1;
        end
        check("bp_accepts", 64'(acc), 64'd2);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_c_held", 64'(bus.c), 64'hFFFFFFFF);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = acc; i < 5; i++) send(vec_a[i], vec_b[i]);
        drain(20);

        // Random streaming at full rate
        lat_chk = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            bus.a = $urandom;
            bus.b = (i % 7 == 0) ? bus.a : $urandom;
            @(negedge clk);
            check("stream_in_ready", 64'(bus.in_ready), 64'd1);
            if (bus.in_ready) q.push_back(model(bus.a, bus.b, cyc));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        drain(10);

        // Random backpressure with random input gaps
        lat_chk = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a = $urandom;
            bus.b = $urandom;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, cyc));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain(10);

        // Mid-operation reset with OUT and SKID both full
        bus.out_ready = 1'b0;
        send(32'h1234_5678, 32'h1234_5678);
        send(32'hA5A5_A5A5, 32'h0F0F_0F0F);
        repeat (2) @(posedge clk);
        #1;
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        q.delete();
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_stale", 64'(bus.out_valid), 64'd0);
        send(32'h0000_00FF, 32'h0000_0000);
        drain(10);

        // WIDTH=1 instance
        bus1.a = 1'b0; bus1.b = 1'b0; bus1.in_valid = 1'b1;
        @(negedge clk);
        check("w1_in_ready", 64'(bus1.in_ready), 64'd1);
        @(posedge clk); #1;
        bus1.a = 1'b1; bus1.b = 1'b0;
        @(negedge clk);
        check("w1_00_valid", 64'(bus1.out_valid), 64'd1);
        check("w1_00_c", 64'(bus1.c), 64'd1);
        check("w1_00_eq", 64'(bus1.eq), 64'd1);
        check("w1_00_cnt", 64'(bus1.match_cnt), 64'd1);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check("w1_10_valid", 64'(bus1.out_valid), 64'd1);
        check("w1_10_c", 64'(bus1.c), 64'd0);
        check("w1_10_eq", 64'(bus1.eq), 64'd0);
        check("w1_10_cnt", 64'(bus1.match_cnt), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("w1_idle", 64'(bus1.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
